cache_mem_requester: RTL and testbench
======================================

# cache_mem_requester

Cache-side initiator for the block memory's Req_Low/Rdy_Low protocol. On a cache miss it writes back the dirty victim block if needed, fetches the missing block, and returns it to the cache controller as a one-cycle fill. It sits between the cache controller and `memory`. It is the only driver of memory's `Req_Low`, `addr`, `din` and `Wr` ports.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting for `Rdy_Low` low in a request state. 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `Rst_Low` in 1: reset, asynchronous, active-low.
- `miss_req` in 1: level; a miss is pending.
- `miss_addr` in 10: block address to fetch.
- `victim_dirty` in 1: victim must be written back first.
- `victim_addr` in 10: victim block address.
- `victim_data` in `Memory_Block_Size`: victim block contents.
- `busy` out 1: high whenever the state is not IDLE.
- `fill_valid` out 1: one-cycle pulse; `fill_data` is valid.
- `fill_data` out `Memory_Block_Size`: fetched block, held until the next fill.
- `err` out 1: one-cycle pulse on timeout.
- `Req_Low` out 1: memory request, active-low.
- `addr` out 10: memory address.
- `din` out `Memory_Block_Size`: memory write data.
- `Wr` out 1: write enable.
- `dout` in `Memory_Block_Size`: memory read data.
- `Rdy_Low` in 1: memory ready, active-low.

## Operation
- All outputs are registered.
- Reset values: `Req_Low`=1; `Wr`=0; `addr`=0; `din`=0; `fill_valid`=0; `fill_data`=0; `busy`=0; `err`=0; state IDLE; timer 0.
- States and transitions:
  - **IDLE**: if `miss_req`=1, capture `miss_addr`. If `victim_dirty`=1, drive `Req_Low`=0, `Wr`=1, `addr`=`victim_addr`, `din`=`victim_data` and go to WB_REQ. Otherwise drive `Req_Low`=0, `Wr`=0, `addr`=`miss_addr` and go to RD_REQ.
  - **WB_REQ**: hold all memory outputs. When `Rdy_Low`=0 is sampled, drive `Req_Low`=1 and `Wr`=0, keep `addr`/`din`, and go to WB_HOLD.
  - **WB_HOLD**: one cycle. Memory registers `Wr` into its write enable a cycle late, so one extra write with the held `addr`/`din` occurs here. That write is harmless only because `addr`/`din` are unchanged. Then go to WB_REL.
  - **WB_REL**: wait for `Rdy_Low`=1. On seeing it, issue the read (`Req_Low`=0, `addr`=captured miss address) and go to RD_REQ.
  - **RD_REQ**: hold outputs. When `Rdy_Low`=0 is sampled: set `fill_data`<=`dout` and `fill_valid`<=1 (one cycle), set `Req_Low`<=1, and go to RD_REL.
  - **RD_REL**: wait for `Rdy_Low`=1, then go to IDLE.
- Handshake rules:
  - `Req_Low` never re-asserts until `Rdy_Low` has been sampled high.
  - `addr`, `din` and `Wr` never change while `Req_Low`=0.
- Timeout:
  - The timer counts cycles in WB_REQ and RD_REQ and clears on every state change.
  - When the count reaches `TIMEOUT_CYCLES` (nonzero): pulse `err`, set `Req_Low`=1 and `Wr`=0, go to RD_REL, and produce no fill.
  - The timer is 8 bits wide and saturates; it never wraps.
- `miss_req` is ignored unless the state is IDLE. Inputs are captured only at acceptance; later changes have no effect.
- If `miss_req` is still high in the cycle after returning to IDLE, a new miss is accepted. The cache controller must drop `miss_req` on `fill_valid`.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately.
  - A write in flight may complete or be repeated at `addr` 0. Memory contents after a mid-write reset are undefined; this is accepted behaviour.

## Timing
- Clean miss, with acceptance at edge E0:
  - Memory asserts `Rdy_Low` low at E1.
  - The block samples it at E2; `fill_valid` is high in the cycle after E2.
  - `Rdy_Low` returns high at E3; the block is in IDLE after E4 (`busy` low).
- Dirty miss, with acceptance at E0:
  - Write request active E0–E2.
  - WB_HOLD in the cycle after E2; WB_REL sees `Rdy_Low`=1 at E4 and issues the read.
  - `fill_valid` is high in the cycle after E6; IDLE after E8.
- `busy` rises in the cycle after acceptance and falls on entry to IDLE.
- `fill_valid` and `err` are never high together.

## Structure
- Shared definitions go in `data_def.v`:
  - `Memory_Block_Size` (existing).
  - New `Mem_Addr_Width` (10).
  - New state encodings: IDLE, WB_REQ, WB_HOLD, WB_REL, RD_REQ, RD_REL.
- One sub-module, `req_timer`: a saturating timeout counter with clear/enable inputs and a `hit` output compared against `TIMEOUT_CYCLES`.

## Test plan
- Clean miss: `miss_addr`=0x155, memory preloaded with 0xA5A5…A5 → single `fill_valid` at E2+1; `fill_data`=0xA5A5…A5; no write (`Wr`=0 throughout).
- Dirty miss: `victim_addr`=0x0F0, `victim_data`=0x1234…, `miss_addr`=0x0F1 → memory[0x0F0]=0x1234… and memory[0x0F1] unchanged; fill at E6+1.
- Back-to-back misses with `miss_req` held high → second read not issued before `Rdy_Low` is seen high; `Req_Low` high for at least 2 cycles between requests.
- Responder stub never asserts `Rdy_Low`, `TIMEOUT_CYCLES`=8 → `err` pulses 8 cycles into RD_REQ; no `fill_valid`; IDLE afterwards.
- `Rst_Low` pulsed in WB_HOLD → `Req_Low`=1, `Wr`=0, `busy`=0 immediately; the next miss completes normally.
- Protocol checker over all scenarios: `addr`, `din` and `Wr` stable whenever `Req_Low`=0; `Req_Low` never falls while `Rdy_Low`=0.

Source files
------------

// File: rtl/cache_mem_requester_pkg.sv
// Shared widths and state encoding for the cache-side memory requester.
package cache_mem_requester_pkg;

   localparam int Memory_Block_Size = 32;
   localparam int Mem_Addr_Width    = 10;
   localparam int Timer_Width       = 8;

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      WB_HOLD,
      WB_REL,
      RD_REQ,
      RD_REL
   } req_state_t;

endpackage

// File: rtl/cache_mem_requester_req_timer.sv
// Saturating wait counter. Raises hit when a request state has lasted
// TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES of 0 disables it.
module req_timer
   import cache_mem_requester_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic clk,
   input  logic Rst_Low,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   localparam logic [Timer_Width-1:0] Limit = Timer_Width'(TIMEOUT_CYCLES - 1);

   logic [Timer_Width-1:0] count;

   always_ff @(posedge clk or negedge Rst_Low) begin
      if (!Rst_Low) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   // The count holds the cycles already spent, so the current cycle is the Nth one at Limit.
   assign hit = (TIMEOUT_CYCLES != 0) && enable && (count == Limit);

endmodule

// File: rtl/cache_mem_requester.sv
// Miss handler: optional dirty write-back, then block fetch returned as a
// one-cycle fill, over the memory's Req_Low/Rdy_Low handshake.
module cache_mem_requester
   import cache_mem_requester_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic                         clk,
   input  logic                         Rst_Low,
   input  logic                         miss_req,
   input  logic [Mem_Addr_Width-1:0]    miss_addr,
   input  logic                         victim_dirty,
   input  logic [Mem_Addr_Width-1:0]    victim_addr,
   input  logic [Memory_Block_Size-1:0] victim_data,
   output logic                         busy,
   output logic                         fill_valid,
   output logic [Memory_Block_Size-1:0] fill_data,
   output logic                         err,
   output logic                         Req_Low,
   output logic [Mem_Addr_Width-1:0]    addr,
   output logic [Memory_Block_Size-1:0] din,
   output logic                         Wr,
   input  logic [Memory_Block_Size-1:0] dout,
   input  logic                         Rdy_Low
);

   req_state_t                   state, state_next;
   logic [Mem_Addr_Width-1:0]    miss_addr_q, miss_addr_next;
   logic [Mem_Addr_Width-1:0]    addr_next;
   logic [Memory_Block_Size-1:0] din_next, fill_data_next;
   logic                         req_low_next, wr_next, fill_valid_next, err_next;
   logic                         timer_hit, timer_clear, timer_enable;

   assign timer_clear  = (state_next != state);
   assign timer_enable = (state == WB_REQ) || (state == RD_REQ);

   req_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .Rst_Low(Rst_Low),
      .clear  (timer_clear),
      .enable (timer_enable),
      .hit    (timer_hit)
   );

   always_ff @(posedge clk or negedge Rst_Low) begin
      if (!Rst_Low) begin
         state       <= IDLE;
         miss_addr_q <= '0;
         Req_Low     <= 1'b1;
         Wr          <= 1'b0;
         addr        <= '0;
         din         <= '0;
         fill_valid  <= 1'b0;
         fill_data   <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_next;
         miss_addr_q <= miss_addr_next;
         Req_Low     <= req_low_next;
         Wr          <= wr_next;
         addr        <= addr_next;
         din         <= din_next;
         fill_valid  <= fill_valid_next;
         fill_data   <= fill_data_next;
         err         <= err_next;
         busy        <= (state_next != IDLE);
      end
   end

   // Memory-facing outputs only move at request launch or release, so they
   // stay frozen for the whole time Req_Low is low.
   always_comb begin
      state_next      = state;
      miss_addr_next  = miss_addr_q;
      req_low_next    = Req_Low;
      wr_next         = Wr;
      addr_next       = addr;
      din_next        = din;
      fill_valid_next = 1'b0;
      fill_data_next  = fill_data;
      err_next        = 1'b0;

      case (state)
         IDLE: begin
            if (miss_req) begin
               miss_addr_next = miss_addr;
               req_low_next   = 1'b0;
               if (victim_dirty) begin
                  wr_next    = 1'b1;
                  addr_next  = victim_addr;
                  din_next   = victim_data;
                  state_next = WB_REQ;
               end else begin
                  wr_next    = 1'b0;
                  addr_next  = miss_addr;
                  state_next = RD_REQ;
               end
            end
         end

         WB_REQ: begin
            if (!Rdy_Low) begin
               req_low_next = 1'b1;
               wr_next      = 1'b0;
               state_next   = WB_HOLD;
            end else if (timer_hit) begin
               err_next     = 1'b1;
               req_low_next = 1'b1;
               wr_next      = 1'b0;
               state_next   = RD_REL;
            end
         end

         // Memory's late write enable repeats the write here with unchanged addr/din.
         WB_HOLD: begin
            state_next = WB_REL;
         end

         WB_REL: begin
            if (Rdy_Low) begin
               req_low_next = 1'b0;
               wr_next      = 1'b0;
               addr_next    = miss_addr_q;
               state_next   = RD_REQ;
            end
         end

         RD_REQ: begin
            if (!Rdy_Low) begin
               fill_data_next  = dout;
               fill_valid_next = 1'b1;
               req_low_next    = 1'b1;
               state_next      = RD_REL;
            end else if (timer_hit) begin
               err_next     = 1'b1;
               req_low_next = 1'b1;
               wr_next      = 1'b0;
               state_next   = RD_REL;
            end
         end

         RD_REL: begin
            if (Rdy_Low) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_requester.sv
// Bench for cache_mem_requester: block memory stub with late write enable,
// scoreboard of expected fills, per-cycle handshake checks and directed misses.
module tb_cache_mem_requester;
   import cache_mem_requester_pkg::*;

   localparam int Aw = Mem_Addr_Width;
   localparam int Dw = Memory_Block_Size;

   logic          clk = 1'b0;
   logic          Rst_Low;
   logic          miss_req;
   logic [Aw-1:0] miss_addr;
   logic          victim_dirty;
   logic [Aw-1:0] victim_addr;
   logic [Dw-1:0] victim_data;
   logic          busy, fill_valid, err, Req_Low, Wr;
   logic [Dw-1:0] fill_data, din;
   logic [Aw-1:0] addr;
   logic [Dw-1:0] dout = '0;
   logic          Rdy_Low = 1'b1;

   int tests = 0;
   int failures = 0;

   logic [Dw-1:0] stubMem  [1024];
   logic [Dw-1:0] modelMem [1024];
   logic          weQ = 1'b0;
   logic          noReady = 1'b0;

   logic [Dw-1:0] expFill [$];
   int            expErr = 0;
   int            errCount = 0;
   logic          wrEver = 1'b0;

   cache_mem_requester #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk         (clk),
      .Rst_Low     (Rst_Low),
      .miss_req    (miss_req),
      .miss_addr   (miss_addr),
      .victim_dirty(victim_dirty),
      .victim_addr (victim_addr),
      .victim_data (victim_data),
      .busy        (busy),
      .fill_valid  (fill_valid),
      .fill_data   (fill_data),
      .err         (err),
      .Req_Low     (Req_Low),
      .addr        (addr),
      .din         (din),
      .Wr          (Wr),
      .dout        (dout),
      .Rdy_Low     (Rdy_Low)
   );

   always #5 clk = ~clk;

   function automatic logic [Dw-1:0] initVal(input int i);
      logic [Dw-1:0] v;
      v = 32'h5A5A0000 | Dw'(i);
      if (i == 'h155) v = 32'hA5A5A5A5;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Memory stub: answers a request one edge after seeing it, latches Wr a cycle late.
   always @(posedge clk) begin
      weQ <= Wr;
      if (weQ) stubMem[addr] <= din;
      if (noReady || Req_Low) begin
         Rdy_Low <= 1'b1;
      end else if (Rdy_Low) begin
         Rdy_Low <= 1'b0;
         dout    <= stubMem[addr];
      end
   end

   // Per-cycle checks: fill scoreboard, err bookkeeping, handshake rules.
   logic          prevReq = 1'b1, prevRdy = 1'b1, prevWr = 1'b0;
   logic [Aw-1:0] prevAddr = '0;
   logic [Dw-1:0] prevDin = '0;
   int            highRun = 100;
   always @(negedge clk) begin
      if (Rst_Low) begin
         if (Wr) wrEver = 1'b1;
         if (fill_valid && err) checkOutput("fill_and_err", 1, 0);
         if (fill_valid) begin
            if (expFill.size() == 0) checkOutput("unexpected_fill", 1, 0);
            else checkOutput("fill_data", fill_data, expFill.pop_front());
         end
         if (err) errCount++;
         if (!prevReq && !Req_Low) begin
            checkOutput("addr_stable", addr, prevAddr);
            checkOutput("din_stable", din, prevDin);
            checkOutput("wr_stable", Wr, prevWr);
         end
         if (prevReq && !Req_Low) begin
            checkOutput("req_fall_rdy_high", prevRdy, 1);
            if (highRun < 2) checkOutput("req_gap_cycles", highRun, 2);
         end
         highRun = Req_Low ? highRun + 1 : 0;
      end else begin
         highRun = 100;
      end
      prevReq  = Req_Low;
      prevRdy  = Rdy_Low;
      prevWr   = Wr;
      prevAddr = addr;
      prevDin  = din;
   end

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("wait_idle_timeout", busy, 0);
   endtask

   // One miss; the *At arguments are expected cycle indices after acceptance (-1 = never).
   task automatic applyStimulus(input string tag, input bit dirty, input logic [Aw-1:0] va,
                                input logic [Dw-1:0] vd, input logic [Aw-1:0] ma,
                                input int fillAt, input int errAt, input int idleAt);
      int fillSeen = -1;
      int errSeen = -1;
      int idleSeen = -1;
      waitIdle();
      @(posedge clk);
      #1;
      miss_req     = 1'b1;
      victim_dirty = dirty;
      victim_addr  = va;
      victim_data  = vd;
      miss_addr    = ma;
      wrEver       = 1'b0;
      if (dirty) modelMem[va] = vd;
      if (fillAt >= 0) expFill.push_back(modelMem[ma]);
      if (errAt >= 0) expErr++;
      @(posedge clk);
      #1;
      miss_req     = 1'b0;
      miss_addr    = ~ma;
      victim_addr  = ~va;
      victim_data  = ~vd;
      victim_dirty = ~dirty;
      for (int k = 0; k < 60 && idleSeen < 0; k++) begin
         @(negedge clk);
         if (fillSeen < 0 && fill_valid) fillSeen = k;
         if (errSeen < 0 && err) errSeen = k;
         if (!busy) idleSeen = k;
      end
      checkOutput({tag, "_fill_cycle"}, 64'(fillSeen), 64'(fillAt));
      checkOutput({tag, "_err_cycle"}, 64'(errSeen), 64'(errAt));
      checkOutput({tag, "_idle_cycle"}, 64'(idleSeen), 64'(idleAt));
      if (!dirty) checkOutput({tag, "_no_write"}, wrEver, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int fills;
      int secondAt;
      for (int i = 0; i < 1024; i++) begin
         stubMem[i]  = initVal(i);
         modelMem[i] = initVal(i);
      end
      Rst_Low      = 1'b0;
      miss_req     = 1'b0;
      miss_addr    = '0;
      victim_dirty = 1'b0;
      victim_addr  = '0;
      victim_data  = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_req_low", Req_Low, 1);
      checkOutput("rst_wr", Wr, 0);
      checkOutput("rst_addr", addr, 0);
      checkOutput("rst_din", din, 0);
      checkOutput("rst_fill_valid", fill_valid, 0);
      checkOutput("rst_fill_data", fill_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      Rst_Low = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus("clean", 1'b0, 10'h000, 32'h0, 10'h155, 2, -1, 4);
      checkOutput("clean_fill_literal", fill_data, 32'hA5A5A5A5);

      applyStimulus("dirty", 1'b1, 10'h0F0, 32'h12345678, 10'h0F1, 6, -1, 8);
      checkOutput("dirty_fill_literal", fill_data, 32'h5A5A00F1);
      @(negedge clk);
      checkOutput("dirty_victim_written", stubMem[10'h0F0], 32'h12345678);
      checkOutput("dirty_miss_untouched", stubMem[10'h0F1], 32'h5A5A00F1);

      // Back-to-back with miss_req held high across the first fill.
      waitIdle();
      @(posedge clk);
      #1;
      miss_req     = 1'b1;
      victim_dirty = 1'b0;
      miss_addr    = 10'h020;
      expFill.push_back(modelMem[10'h020]);
      @(posedge clk);
      fills = 0;
      secondAt = -1;
      for (int k = 0; k < 40 && secondAt < 0; k++) begin
         @(negedge clk);
         if (fill_valid) begin
            fills++;
            if (fills == 1) begin
               miss_addr = 10'h021;
               expFill.push_back(modelMem[10'h021]);
            end else begin
               secondAt = k;
               miss_req = 1'b0;
            end
         end
      end
      checkOutput("b2b_second_fill_cycle", 64'(secondAt), 64'd7);
      checkOutput("b2b_second_fill_literal", fill_data, 32'h5A5A0021);

      // Memory never answers: timeout then release.
      noReady = 1'b1;
      applyStimulus("timeout", 1'b0, 10'h000, 32'h0, 10'h010, -1, 8, 9);
      noReady = 1'b0;
      checkOutput("timeout_err_count", 64'(errCount), 64'(expErr));

      // Reset pulsed during WB_HOLD.
      waitIdle();
      @(posedge clk);
      #1;
      miss_req     = 1'b1;
      victim_dirty = 1'b1;
      victim_addr  = 10'h300;
      victim_data  = 32'hDEADBEEF;
      miss_addr    = 10'h301;
      @(posedge clk);
      #1;
      miss_req = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("hold_req_released", Req_Low, 1);
      checkOutput("hold_busy", busy, 1);
      Rst_Low = 1'b0;
      #1;
      checkOutput("midrst_req_low", Req_Low, 1);
      checkOutput("midrst_wr", Wr, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_addr", addr, 0);
      #1;
      Rst_Low = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus("after_rst", 1'b0, 10'h000, 32'h0, 10'h301, 2, -1, 4);
      checkOutput("after_rst_fill_literal", fill_data, 32'h5A5A0301);

      repeat (3) @(negedge clk);
      checkOutput("pending_fills", 64'(expFill.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
